alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk_buf2  in  1  clock; all state updates on the rising edge.
REQ-003 Port: reset_buf2  in  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  in  1  operand bundle from the decode buffer is valid.
REQ-005 Port: in_ready  out  1  block accepts the bundle this cycle.
REQ-006 Port: op_a  in  32  operand A (decode buffer output 1).
REQ-007 Port: op_b  in  32  operand B (decode buffer output 2); shift amount is op_b[4:0].
REQ-008 Port: alu_func  in  4  operation code.
REQ-009 Port: out_valid  out  1  result bundle is valid.
REQ-010 Port: out_ready  in  1  downstream accepts the result.
REQ-011 Port: result  out  32  registered result.
REQ-012 Port: zero  out  1  registered; 1 when result==0.
REQ-013 Port: ovf  out  1  registered; signed overflow for ADD/SUB, else 0.

Function
REQ-014 Codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT (signed, 1/0), 8 SRL, 9 SRA, 10 MUL (low 32 bits, unsigned), 11 DIVU quotient, 12 REMU; 13-15 reserved -> result 0, ovf 0, single-cycle.
REQ-015 Transfer occurs on a rising edge where in_valid && in_ready (input) or out_valid && out_ready (output).
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 in_ready = 1 in IDLE; = out_ready in DONE; = 0 in BUSY.
REQ-018 IDLE + accept single-cycle op -> DONE; result/zero/ovf registered on the accepting edge, out_valid=1 after that edge (latency 1).
REQ-019 IDLE + accept code 10-12 -> BUSY; iteration counter loaded with 31, decremented on each BUSY edge.
REQ-020 BUSY with counter==0 -> DONE on that edge with final result; out_valid asserts after the 32nd edge following acceptance (latency 32).
REQ-021 MUL: shift-add, one multiplier bit per cycle, upper product bits discarded.
REQ-022 DIVU/REMU: restoring division, one quotient bit per cycle, unsigned.
REQ-023 Divide by zero: quotient 32'hFFFF_FFFF, remainder = op_a; still takes 32 cycles.
REQ-024 DONE, out_ready=0: result, zero, ovf and out_valid held stable; inputs ignored.
REQ-025 DONE, out_ready=1, in_valid=0 -> IDLE, out_valid=0.
REQ-026 DONE, out_ready=1, in_valid=1 (simultaneous): old result retires and new op is accepted on the same edge; single-cycle -> stays DONE with new result; iterative -> BUSY, out_valid=0.
REQ-027 Operands and alu_func are captured on acceptance; later input changes do not affect an operation in flight.
REQ-028 Shift amounts use op_b[4:0] only; SRA replicates op_a[31].
REQ-029 ovf (ADD/SUB) is computed from sign bits; the result still wraps modulo 2^32.

Reset
REQ-030 reset_buf2=1 forces state IDLE, counter 0, result 0, zero 0, ovf 0, out_valid 0 immediately, independent of clk_buf2.
REQ-031 Reset during BUSY or DONE discards the operation; no result is produced after release.
REQ-032 After release, the first accept can occur on the first rising edge with in_valid=1.

Structure
REQ-033 Package alu_pkg holds the alu_func code constants, the FSM state encoding and DATA_W.
REQ-034 The iterative multiply/divide datapath (partial product/remainder, quotient, counter) resides in sub-module alu_iter_md with start/done signalling; alu_exec contains the FSM, the single-cycle ALU and the output register.

Verification
REQ-035 ADD 0x7FFF_FFFF + 1, out_ready=1 -> out_valid 1 edge later, result 0x8000_0000, ovf=1, zero=0.
REQ-036 SUB 5-5, then SLT 0xFFFF_FFFF vs 1 back-to-back, out_ready=1 -> results 0 (zero=1) then 1, in consecutive cycles.
REQ-037 MUL 0x0001_0003 * 0x0002_0005 -> out_valid after 32 edges, result 0x000B_000F; in_ready=0 throughout BUSY.
REQ-038 DIVU 100/7 then REMU 100/7 -> 14 then 2; DIVU 9/0 -> 0xFFFF_FFFF; REMU 9/0 -> 9.
REQ-039 Result 0x1234 with out_ready=0 for 5 cycles while in_valid toggles -> result held, no accept; out_ready=1 with in_valid=1 -> retire and accept on the same edge.
REQ-040 Assert reset_buf2 mid-DIVU at cycle 10 -> outputs 0 and IDLE immediately; after release, ADD 2+3 -> result 5.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_pkg : shared widths, opcodes and state encodings for alu_exec |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] FN_AND  = 4'd0;
    localparam logic [3:0] FN_OR   = 4'd1;
    localparam logic [3:0] FN_ADD  = 4'd2;
    localparam logic [3:0] FN_XOR  = 4'd3;
    localparam logic [3:0] FN_NOR  = 4'd4;
    localparam logic [3:0] FN_SLL  = 4'd5;
    localparam logic [3:0] FN_SUB  = 4'd6;
    localparam logic [3:0] FN_SLT  = 4'd7;
    localparam logic [3:0] FN_SRL  = 4'd8;
    localparam logic [3:0] FN_SRA  = 4'd9;
    localparam logic [3:0] FN_MUL  = 4'd10;
    localparam logic [3:0] FN_DIVU = 4'd11;
    localparam logic [3:0] FN_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_t;

    function automatic logic is_iter(input logic [3:0] fn);
        return (fn == FN_MUL) || (fn == FN_DIVU) || (fn == FN_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_exec_if : operand/result handshake bundle of alu_exec       |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
interface alu_exec_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        alu_func;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;

    modport master (
        output in_valid, op_a, op_b, alu_func, out_ready,
        input  in_ready, out_valid, result, zero, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, alu_func, out_ready,
        output in_ready, out_valid, result, zero, ovf
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter_md.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_iter_md : 32-step shift-add multiplier / restoring divider  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module alu_iter_md
    import alu_pkg::*;
(
    input  logic              clk_buf2,
    input  logic              reset_buf2,
    input  logic              start,
    input  md_op_t            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] res
);
    // acc: product or partial remainder; x: multiplicand or divisor;
    // y: multiplier bits or dividend shifting out / quotient shifting in
    logic              busy_q, busy_d;
    logic [4:0]        cnt_q, cnt_d;
    md_op_t            op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0] acc_step, x_step, y_step;
    logic [DATA_W:0]   rem_sh, diff;

    always_comb begin
        rem_sh   = {acc_q, y_q[DATA_W-1]};
        diff     = rem_sh - {1'b0, x_q};
        acc_step = acc_q;
        x_step   = x_q;
        y_step   = y_q;
        if (op_q == MD_MUL) begin
            acc_step = acc_q + (y_q[0] ? x_q : '0);
            x_step   = x_q << 1;
            y_step   = y_q >> 1;
        end else if (!diff[DATA_W]) begin
            acc_step = diff[DATA_W-1:0];
            y_step   = {y_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_step = rem_sh[DATA_W-1:0];
            y_step   = {y_q[DATA_W-2:0], 1'b0};
        end
    end

    assign done = busy_q && (cnt_q == 5'd0);
    assign res  = (op_q == MD_DIVU) ? y_step : acc_step;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 5'd31;
            op_d   = op;
            acc_d  = '0;
            x_d    = (op == MD_MUL) ? a : b;
            y_d    = (op == MD_MUL) ? b : a;
        end else if (busy_q) begin
            acc_d = acc_step;
            x_d   = x_step;
            y_d   = y_step;
            if (cnt_q == 5'd0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk_buf2 or posedge reset_buf2) begin
        if (reset_buf2) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
            op_q   <= MD_MUL;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_exec : handshaked ALU, single-cycle ops plus iterative MD   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic      clk_buf2,
    input  logic      reset_buf2,
    alu_exec_if.slave bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_res, sum, dif, md_res;
    logic              alu_ovf, in_ready, accept, md_start, md_done;
    logic [4:0]        shamt;
    md_op_t            md_op;

    assign shamt = bus.op_b[4:0];
    assign sum   = bus.op_a + bus.op_b;
    assign dif   = bus.op_a - bus.op_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_func)
            FN_AND: alu_res = bus.op_a & bus.op_b;
            FN_OR:  alu_res = bus.op_a | bus.op_b;
            FN_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.op_a[DATA_W-1] == bus.op_b[DATA_W-1]) &&
                          (sum[DATA_W-1] != bus.op_a[DATA_W-1]);
            end
            FN_XOR: alu_res = bus.op_a ^ bus.op_b;
            FN_NOR: alu_res = ~(bus.op_a | bus.op_b);
            FN_SLL: alu_res = bus.op_a << shamt;
            FN_SUB: begin
                alu_res = dif;
                alu_ovf = (bus.op_a[DATA_W-1] != bus.op_b[DATA_W-1]) &&
                          (dif[DATA_W-1] != bus.op_a[DATA_W-1]);
            end
            FN_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            FN_SRL: alu_res = bus.op_a >> shamt;
            FN_SRA: alu_res = $signed(bus.op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        md_op = MD_REMU;
        if (bus.alu_func == FN_MUL) begin
            md_op = MD_MUL;
        end else if (bus.alu_func == FN_DIVU) begin
            md_op = MD_DIVU;
        end
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    alu_iter_md u_md (
        .clk_buf2   (clk_buf2),
        .reset_buf2 (reset_buf2),
        .start      (md_start),
        .op         (md_op),
        .a          (bus.op_a),
        .b          (bus.op_b),
        .done       (md_done),
        .res        (md_res)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        md_start    = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (md_done) begin
                    state_d     = ST_DONE;
                    result_d    = md_res;
                    zero_d      = (md_res == '0);
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        // An accept in DONE retires the held result on the same edge
        if (accept) begin
            if (is_iter(bus.alu_func)) begin
                state_d     = ST_BUSY;
                md_start    = 1'b1;
                out_valid_d = 1'b0;
            end else begin
                state_d     = ST_DONE;
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                ovf_d       = alu_ovf;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_buf2 or posedge reset_buf2) begin
        if (reset_buf2) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_alu_exec : directed vectors plus cycle-level reference model |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_alu_exec;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_exec_if bus ();

    alu_exec #(.DATA_W(32)) dut (
        .clk_buf2   (clk),
        .reset_buf2 (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference semantics from plain arithmetic; returns {ovf, result}
    function automatic logic [32:0] ref_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        longint      s;
        r = '0;
        o = 1'b0;
        case (fn)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = a << b[4:0];
            4'd6:  begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = a >> b[4:0];
            4'd9:  r = $signed(a) >>> b[4:0];
            4'd10: r = a * b;
            4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    // Model: pending iterative result appears 32 edges after acceptance
    logic        m_valid, m_zero, m_ovf, m_rdy, m_iter, m_o;
    logic [31:0] m_res, p_res, m_r;
    int          m_busy;

    always_comb begin
        m_rdy     = (m_busy == 0) && (!m_valid || bus.out_ready);
        {m_o, m_r} = ref_op(bus.alu_func, bus.op_a, bus.op_b);
        m_iter    = (bus.alu_func >= 4'd10) && (bus.alu_func <= 4'd12);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_res   <= '0;
            m_zero  <= 1'b0;
            m_ovf   <= 1'b0;
            m_busy  <= 0;
            p_res   <= '0;
        end else if (bus.in_valid && m_rdy) begin
            if (m_iter) begin
                m_busy  <= 32;
                p_res   <= m_r;
                m_valid <= 1'b0;
            end else begin
                m_valid <= 1'b1;
                m_res   <= m_r;
                m_zero  <= (m_r == 0);
                m_ovf   <= m_o;
            end
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1;
                m_res   <= p_res;
                m_zero  <= (p_res == 0);
                m_ovf   <= 1'b0;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("mdl_in_ready", bus.in_ready, m_rdy);
        chk("mdl_out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            chk("mdl_result", bus.result, m_res);
            chk("mdl_zero", bus.zero, m_zero);
            chk("mdl_ovf", bus.ovf, m_ovf);
        end
    end

    task automatic send(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        bus.alu_func = fn;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 100) chk("send_timeout", 32'(g), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom();
        bus.op_b     = $urandom();
        bus.alu_func = 4'($urandom_range(0, 15));
    endtask

    // lat_exp: edges after the accepting edge before out_valid is seen
    task automatic wait_result(input string nm, input int lat_exp, input logic [31:0] r,
                               input logic z, input logic o);
        int lat = 0;
        while (!bus.out_valid && lat < 100) begin
            chk({nm, "_busy_rdy"}, bus.in_ready, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({nm, "_res"}, bus.result, r);
        chk({nm, "_zero"}, bus.zero, z);
        chk({nm, "_ovf"}, bus.ovf, o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.alu_func  = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", bus.zero, 32'd0);
        chk("rst_ovf", bus.ovf, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'd1);
        idle(2);
        rst = 1'b0;

        send(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_result("add_ovf", 0, 32'h8000_0000, 1'b0, 1'b1);

        idle(2);
        send(4'd6, 32'd5, 32'd5);
        wait_result("sub_zero", 0, 32'h0, 1'b1, 1'b0);
        send(4'd7, 32'hFFFF_FFFF, 32'h1);
        wait_result("slt_neg", 0, 32'h1, 1'b0, 1'b0);

        send(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
        wait_result("and", 0, 32'h00F0_1200, 1'b0, 1'b0);
        send(4'd3, 32'hFFFF_0000, 32'h0F0F_0F0F);
        wait_result("xor", 0, 32'hF0F0_0F0F, 1'b0, 1'b0);
        send(4'd4, 32'h0, 32'h0);
        wait_result("nor", 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(4'd5, 32'h1, 32'h0000_0024);
        wait_result("sll_mask", 0, 32'h10, 1'b0, 1'b0);
        send(4'd8, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("srl", 0, 32'h1, 1'b0, 1'b0);
        send(4'd9, 32'h8000_0000, 32'h4);
        wait_result("sra", 0, 32'hF800_0000, 1'b0, 1'b0);
        send(4'd6, 32'h8000_0000, 32'h1);
        wait_result("sub_ovf", 0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send(4'd2, 32'hFFFF_FFFF, 32'h1);
        wait_result("add_wrap", 0, 32'h0, 1'b1, 1'b0);
        send(4'd7, 32'h1, 32'hFFFF_FFFF);
        wait_result("slt_pos", 0, 32'h0, 1'b1, 1'b0);
        send(4'd13, 32'd5, 32'd5);
        wait_result("reserved", 0, 32'h0, 1'b1, 1'b0);

        idle(1);
        send(4'd10, 32'h0001_0003, 32'h0002_0005);
        wait_result("mul", 32, 32'h000B_000F, 1'b0, 1'b0);
        send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mul_max", 32, 32'h1, 1'b0, 1'b0);
        send(4'd11, 32'd100, 32'd7);
        wait_result("divu", 32, 32'd14, 1'b0, 1'b0);
        send(4'd12, 32'd100, 32'd7);
        wait_result("remu", 32, 32'd2, 1'b0, 1'b0);
        send(4'd11, 32'd9, 32'd0);
        wait_result("divu_by0", 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(4'd12, 32'd9, 32'd0);
        wait_result("remu_by0", 32, 32'd9, 1'b0, 1'b0);

        idle(2);
        bus.out_ready = 1'b0;
        send(4'd1, 32'h0000_1230, 32'h0000_0004);
        wait_result("or_hold", 0, 32'h0000_1234, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.alu_func = 4'd2;
            bus.op_a     = 32'd1;
            bus.op_b     = 32'd1;
            bus.in_valid = (i % 2 == 0);
            #1;
            chk("hold_in_ready", bus.in_ready, 32'd0);
            chk("hold_valid", bus.out_valid, 32'd1);
            chk("hold_result", bus.result, 32'h0000_1234);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        send(4'd2, 32'd7, 32'd8);
        wait_result("retire_accept", 0, 32'd15, 1'b0, 1'b0);

        idle(2);
        send(4'd11, 32'd100, 32'd7);
        idle(9);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_zero", bus.zero, 32'd0);
        chk("midrst_in_ready", bus.in_ready, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        send(4'd2, 32'd2, 32'd3);
        wait_result("post_rst_add", 0, 32'd5, 1'b0, 1'b0);
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
